ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 3000: PS/2 clock-inhibit time in clk25 cycles (120 us).
REQ-002 SHALL have parameter START_TIMEOUT, default 375000: maximum cycles from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter BIT_TIMEOUT, default 50000: maximum cycles between successive device falling edges, and in WAIT_IDLE (2 ms).
REQ-004 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a new line level.
REQ-005 SHALL have port clk25, input, 1: the single clock (25 MHz).
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port tx_data, input, 8: command byte to send to the keyboard.
REQ-008 SHALL have port tx_valid, input, 1: a send request, accepted when tx_valid and tx_ready are both 1.
REQ-009 SHALL have port tx_ready, output, 1: 1 only in IDLE.
REQ-010 SHALL have port tx_done, output, 1: one-cycle pulse when a byte is acknowledged and the bus is idle.
REQ-011 SHALL have port tx_error, output, 1: one-cycle pulse on missing ack or timeout.
REQ-012 SHALL have ports ps2_clk_in and ps2_data_in, input, 1 each: raw asynchronous pad levels.
REQ-013 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each: 1 means pull the pad low (open-drain); 0 means release.

Function
REQ-014 SHALL pass both pad inputs through a 2-flop synchronizer and then the FILTER_LEN filter; "falling edge" means the filtered ps2_clk goes 1->0.
REQ-015 SHALL, on acceptance in IDLE, latch tx_data and odd parity (parity = XNOR-reduction of the data), then enter INHIBIT.
REQ-016 SHALL, in INHIBIT, drive ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-017 SHALL, in START, drive ps2_clk_oe=1 and ps2_data_oe=1 for 25 cycles, then enter SHIFT with ps2_clk_oe=0 and ps2_data_oe=1 (the start bit).
REQ-018 SHALL, in SHIFT, on falling edges 1..10, set ps2_data_oe to the inverse of the next bit: data[0..7] LSB first, then parity, then stop (1, so the line is released).
REQ-019 SHALL, in ACK, sample filtered ps2_data on the 11th falling edge; 0 enters WAIT_IDLE, 1 pulses tx_error and enters IDLE.
REQ-020 SHALL, in WAIT_IDLE, wait until filtered clk and data are both 1, then pulse tx_done and enter IDLE.
REQ-021 SHALL count timeouts as follows: START_TIMEOUT from SHIFT entry to edge 1; BIT_TIMEOUT between later edges and in WAIT_IDLE. On expiry it SHALL release both lines, pulse tx_error and enter IDLE.
REQ-022 SHALL ignore tx_valid outside IDLE; a new request SHALL be accepted no earlier than the cycle after a tx_done or tx_error pulse.
REQ-023 SHALL register tx_done and tx_error, and SHALL never assert both in the same cycle.
REQ-024 SHALL keep ps2_clk_oe=0 in every state except INHIBIT and START.

Reset
REQ-025 SHALL, while rst_n=0 at a clk25 edge, force: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, tx_ready=0, counters 0, synchronizer and filter outputs 1.
REQ-026 SHALL assert tx_ready=1 on the first cycle after rst_n returns to 1.
REQ-027 SHALL, if reset occurs mid-transfer, release both lines on the next edge and emit no tx_done or tx_error pulse.

Structure
REQ-028 SHALL take its state encoding (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE) and the START hold constant (25) from the shared package ps2_pkg.
REQ-029 SHALL implement the synchronizer and filter as sub-module ps2_line_filter, instantiated once per line.

Verification
REQ-030 SHALL verify: tx_data=0xED with an acking device model -> host drives the bit sequence 1,0,1,1,0,1,1,1, then parity 1, then stop 1, and tx_done pulses once.
REQ-031 SHALL verify: tx_data=0x01 -> parity bit 0, and the inhibit low time is exactly 3000 cycles.
REQ-032 SHALL verify: device holds data high on the ack edge -> one tx_error pulse, no tx_done, and both oe=0.
REQ-033 SHALL verify: device never clocks -> tx_error pulses 375000 cycles after SHIFT entry.
REQ-034 SHALL verify: a 4-cycle low glitch on ps2_clk_in during SHIFT -> bit index unchanged.
REQ-035 SHALL verify: rst_n=0 after edge 5 -> both oe=0 on the next edge, no pulse, and tx_ready=1 one cycle after release.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM encoding, frame layout and parity helper.
package ps2_pkg;

  localparam int unsigned DATA_BITS         = 8;
  localparam int unsigned FRAME_BITS        = DATA_BITS + 2;
  localparam int unsigned START_HOLD_CYCLES = 25;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Bits after the start bit, LSB of data first on the wire.
  typedef struct packed {
    logic                 stop;
    logic                 parity;
    logic [DATA_BITS-1:0] data;
  } ps2_frame_t;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

  function automatic ps2_frame_t make_frame(input logic [DATA_BITS-1:0] d);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = odd_parity(d);
    f.data   = d;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/response handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_error
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter for one PS/2 pad.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] run_q;
  logic             level_q;

  // Bring the asynchronous pad into the clk25 domain; idle level of the bus is high.
  always_ff @(posedge clk25) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], line_in};
  end

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      run_q   <= '0;
    end else if (sync_q[1] == level_q) begin
      run_q <= '0;
    end else if (run_q == CNT_W'(FILTER_LEN - 1)) begin
      level_q <= sync_q[1];
      run_q   <= '0;
    end else begin
      run_q <= run_q + CNT_W'(1);
    end
  end

  assign line_out = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits,
// parity and stop on device clock edges, then check the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 3000,
  parameter int unsigned START_TIMEOUT  = 375000,
  parameter int unsigned BIT_TIMEOUT    = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic           clk25,
  input  logic           rst_n,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int unsigned MAX_AB = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int unsigned MAX_AI = (MAX_AB > INHIBIT_CYCLES) ? MAX_AB : INHIBIT_CYCLES;
  localparam int unsigned MAX_T  = (MAX_AI > START_HOLD_CYCLES) ? MAX_AI : START_HOLD_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
  localparam int unsigned BIT_W  = 4;

  ps2_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  clk_oe_q, clk_oe_d;
  logic                  data_oe_q, data_oe_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  clk_prev_q;

  logic                  clk_f;
  logic                  data_f;
  logic                  fall_c;
  logic                  expired_c;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .line_in  (ps2_clk_in),
    .line_out (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .line_in  (ps2_data_in),
    .line_out (data_f)
  );

  assign fall_c = clk_prev_q & ~clk_f;

  // The wait for the first device edge gets the long start budget; every later wait the bit budget.
  always_comb begin
    if (state_q == SHIFT && bit_q == BIT_W'(0)) expired_c = (cnt_q == CNT_W'(START_TIMEOUT - 1));
    else                                        expired_c = (cnt_q == CNT_W'(BIT_TIMEOUT - 1));
  end

  // Register the FSM state, counters and every output.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      clk_prev_q <= clk_f;
    end
  end

  // Next-state and next-output logic of the transmit sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx.tx_valid && ready_q) begin
          shift_d  = make_frame(tx.tx_data);
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      START: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
        if (cnt_q == CNT_W'(START_HOLD_CYCLES - 1)) begin
          cnt_d    = '0;
          bit_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (fall_c) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
          cnt_d     = '0;
          bit_d     = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(FRAME_BITS - 1)) state_d = ACK;
        end else if (expired_c) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ACK: begin
        if (fall_c) begin
          cnt_d = '0;
          if (!data_f) begin
            state_d = WAIT_IDLE;
          end else begin
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            state_d   = IDLE;
          end
        end else if (expired_c) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (clk_f && data_f) begin
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (expired_c) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase

    // Hold off new requests during the completion pulse so acceptance lands strictly after it.
    ready_d = (state_d == IDLE) && !done_d && !err_d;
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a simple PS/2 device model on the open-drain pads.
module tb_ps2_host_tx;

  localparam int unsigned T_INH   = 3000;
  localparam int unsigned T_START = 4000;
  localparam int unsigned T_BIT   = 1000;
  localparam int          HALF    = 40;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RESET  = 4;

  typedef struct {
    bit          err;
    bit          chk_frame;
    logic [9:0]  frame;
    int unsigned latency;
  } exp_t;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in;
  logic [9:0] dev_frame = '0;

  int unsigned cyc = 0;
  int unsigned shift_cyc = 0;
  int unsigned inhib_cnt = 0;
  int          n_pulse = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        sb[$];

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (T_INH),
    .START_TIMEOUT  (T_START),
    .BIT_TIMEOUT    (T_BIT),
    .FILTER_LEN     (8)
  ) dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .tx          (tx_if.slave),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Open-drain wired-AND of host and device with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t mk_exp(input bit err, input bit chk_frame, input logic [9:0] frame,
                                  input int unsigned latency);
    exp_t e;
    e.err       = err;
    e.chk_frame = chk_frame;
    e.frame     = frame;
    e.latency   = latency;
    return e;
  endfunction

  // Monitor: measure inhibit time and SHIFT entry, pop and compare on every done/error pulse.
  initial begin
    logic prev_clk_oe;
    exp_t e;
    prev_clk_oe = 1'b0;
    forever begin
      @(negedge clk25);
      if (ps2_clk_oe && !ps2_data_oe) inhib_cnt++;
      else if (tx_if.tx_ready)        inhib_cnt = 0;
      if (rst_n && prev_clk_oe && !ps2_clk_oe) shift_cyc = cyc;
      prev_clk_oe = ps2_clk_oe;
      if (tx_if.tx_done || tx_if.tx_error) begin
        n_pulse++;
        chk("done_error_exclusive", int'(tx_if.tx_done & tx_if.tx_error), 0);
        chk("pulse_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("pulse_is_error", int'(tx_if.tx_error), int'(e.err));
          chk("inhibit_len", int'(inhib_cnt), int'(T_INH));
          chk("oe_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
          if (e.chk_frame) chk("frame_bits", int'(dev_frame), int'(e.frame));
          if (e.latency != 0) chk("timeout_latency", int'(cyc - shift_cyc), int'(e.latency));
        end
      end
    end
  end

  // Device model: waits for request-to-send, then clocks 11 edges and optionally acks.
  task automatic dev_run(input int mode);
    int n;
    n = 0;
    dev_frame = '0;
    while (!(ps2_clk_in && !ps2_data_in) && n < 6000) begin
      @(negedge clk25);
      n++;
    end
    chk("dev_saw_request", int'(ps2_clk_in && !ps2_data_in), 1);
    if (mode == M_SILENT) return;
    repeat (20) @(negedge clk25);
    for (int e = 1; e <= 11; e++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk25);
      if (e <= 10) dev_frame[e-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (e == 5 && mode == M_RESET) return;
      if (e == 10 && mode != M_NACK) dev_data_low = 1'b1;
      if (e == 3 && mode == M_GLITCH) begin
        repeat (20) @(negedge clk25);
        dev_clk_low = 1'b1;
        repeat (4) @(negedge clk25);
        dev_clk_low = 1'b0;
        repeat (HALF - 24) @(negedge clk25);
      end else begin
        repeat (HALF) @(negedge clk25);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic do_send(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    while (!tx_if.tx_ready && n < 10000) begin
      @(negedge clk25);
      n++;
    end
    chk("ready_before_send", int'(tx_if.tx_ready), 1);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk25);
    tx_if.tx_valid = 1'b0;
    chk("ready_drops_on_accept", int'(tx_if.tx_ready), 0);
    if (hold) begin
      tx_if.tx_data  = 8'h00;
      tx_if.tx_valid = 1'b1;
      repeat (100) @(negedge clk25);
      chk("ready_low_while_busy", int'(tx_if.tx_ready), 0);
      tx_if.tx_valid = 1'b0;
    end
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 9000 && sb.size() != 0; i++) @(negedge clk25);
    chk("response_seen", sb.size(), 0);
    repeat (5) @(negedge clk25);
  endtask

  initial begin
    int p0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    // Reset state
    repeat (5) @(negedge clk25);
    chk("reset_outputs",
        int'({tx_if.tx_ready, ps2_clk_oe, ps2_data_oe, tx_if.tx_done, tx_if.tx_error}), 0);
    rst_n = 1'b1;
    @(negedge clk25);
    chk("ready_after_reset", int'(tx_if.tx_ready), 1);

    // 0xED acked: 1,0,1,1,0,1,1,1 then parity 1, stop 1; busy requests ignored
    sb.push_back(mk_exp(1'b0, 1'b1, 10'b1_1_1110_1101, 0));
    fork
      do_send(8'hED, 1'b1);
      dev_run(M_ACK);
    join
    wait_resp();

    // 0x01 acked: parity 0
    sb.push_back(mk_exp(1'b0, 1'b1, 10'b1_0_0000_0001, 0));
    fork
      do_send(8'h01, 1'b0);
      dev_run(M_ACK);
    join
    wait_resp();

    // 0x80 with data left high on the ack edge: error, no done
    sb.push_back(mk_exp(1'b1, 1'b1, 10'b1_0_1000_0000, 0));
    fork
      do_send(8'h80, 1'b0);
      dev_run(M_NACK);
    join
    wait_resp();

    // Device never clocks: error exactly START_TIMEOUT cycles after SHIFT entry
    sb.push_back(mk_exp(1'b1, 1'b0, 10'b0, T_START));
    fork
      do_send(8'h55, 1'b0);
      dev_run(M_SILENT);
    join
    wait_resp();

    // 4-cycle clock glitch during SHIFT must not advance the bit index
    sb.push_back(mk_exp(1'b0, 1'b1, 10'b1_1_0011_1100, 0));
    fork
      do_send(8'h3C, 1'b0);
      dev_run(M_GLITCH);
    join
    wait_resp();

    // Reset after edge 5: lines released on the next edge, no pulse, ready one cycle after release
    fork
      do_send(8'hA7, 1'b0);
      dev_run(M_RESET);
    join
    p0 = n_pulse;
    rst_n = 1'b0;
    @(negedge clk25);
    chk("reset_mid_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("reset_mid_ready", int'(tx_if.tx_ready), 0);
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;
    @(negedge clk25);
    chk("ready_after_mid_reset", int'(tx_if.tx_ready), 1);
    repeat (50) @(negedge clk25);
    chk("no_pulse_on_reset", n_pulse - p0, 0);

    // Recovery transfer 0x5A: 0,1,0,1,1,0,1,0 then parity 1, stop 1
    sb.push_back(mk_exp(1'b0, 1'b1, 10'b1_1_0101_1010, 0));
    fork
      do_send(8'h5A, 1'b0);
      dev_run(M_ACK);
    join
    wait_resp();

    chk("total_pulses", n_pulse, 6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
